// File: rtl/rot_share_arb_pkg.sv
// Shared constants, types and the rotate-right helper for the shared rotator arbiter.
package rot_share_pkg;

  localparam int DATA_W = 4;
  localparam int AMT_W  = 2;

  typedef logic [AMT_W-1:0] rot_amt_t;

  typedef enum logic {EMPTY, FULL} out_state_e;

  function automatic logic [DATA_W-1:0] rot_right(input logic [DATA_W-1:0] data, input rot_amt_t amt);
    logic [DATA_W-1:0] res;
    case (amt)
      2'd0:    res = data;
      2'd1:    res = {data[0], data[3:1]};
      2'd2:    res = {data[1:0], data[3:2]};
      default: res = {data[2:0], data[3]};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rot_share_arb_if.sv
// Request/result bundle of the shared rotator; ROT_SHARE_DIR_EN adds per-request direction.
interface rot_share_arb_if #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
);
  import rot_share_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [DATA_W*NREQ-1:0] req_data;
  logic [AMT_W*NREQ-1:0]  req_amt;
  logic [NREQ-1:0]        req_ready;
  logic                   out_valid;
  logic [DATA_W-1:0]      out_data;
  logic [IDW-1:0]         out_id;
  logic                   out_ready;
`ifdef ROT_SHARE_DIR_EN
  logic [NREQ-1:0]        req_dir;
  logic                   out_dir;

  modport master (output req_valid, req_data, req_amt, req_dir, out_ready,
                  input  req_ready, out_valid, out_data, out_id, out_dir);
  modport slave  (input  req_valid, req_data, req_amt, req_dir, out_ready,
                  output req_ready, out_valid, out_data, out_id, out_dir);
`else
  modport master (output req_valid, req_data, req_amt, out_ready,
                  input  req_ready, out_valid, out_data, out_id);
  modport slave  (input  req_valid, req_data, req_amt, out_ready,
                  output req_ready, out_valid, out_data, out_id);
`endif
endinterface

// File: rtl/rot_share_arb_rot4.sv
// Combinational 4-bit rotator; with ROT_SHARE_DIR_EN a set dir rotates left.
module rot4_unit
  import rot_share_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  rot_amt_t          amt,
`ifdef ROT_SHARE_DIR_EN
  input  logic              dir,
`endif
  output logic [DATA_W-1:0] result
);

`ifdef ROT_SHARE_DIR_EN
  // Left by amt equals right by (4 - amt) mod 4, i.e. the two's complement of amt.
  rot_amt_t eff_amt;
  assign eff_amt = dir ? rot_amt_t'(2'd0 - amt) : amt;
  assign result  = rot_right(data, eff_amt);
`else
  assign result = rot_right(data, amt);
`endif

endmodule

// File: rtl/rot_share_arb.sv
// Round-robin arbiter sharing one rotator among NREQ requesters; macro ROT_SHARE_DIR_EN adds direction.
module rot_share_arb
  import rot_share_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  rot_share_arb_if.slave bus
);

  out_state_e        state_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic [IDW-1:0]    out_id_reg;
  logic [IDW-1:0]    last_grant_reg;

  logic [DATA_W-1:0] data_arr [NREQ];
  rot_amt_t          amt_arr  [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign data_arr[gi] = bus.req_data[DATA_W*gi +: DATA_W];
      assign amt_arr[gi]  = bus.req_amt[AMT_W*gi +: AMT_W];
    end
  endgenerate

  logic              load_en;
  logic              found;
  int                idx;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    sel_id;
  logic [DATA_W-1:0] sel_data;
  rot_amt_t          sel_amt;
  logic [DATA_W-1:0] rot_data;
  logic              accept;

  assign load_en = (state_reg == EMPTY) || bus.out_ready;

  // First valid requester after the last grant, wrapping around.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    idx      = 0;
    sel_id   = '0;
    sel_data = '0;
    sel_amt  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant_reg) + k) % NREQ;
      if (!found && bus.req_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        sel_id     = IDW'(idx);
        sel_data   = data_arr[idx];
        sel_amt    = amt_arr[idx];
      end
    end
  end

  assign bus.req_ready = (rst_n && load_en) ? grant : '0;
  assign accept        = |bus.req_ready;

`ifdef ROT_SHARE_DIR_EN
  logic sel_dir;
  logic out_dir_reg;
  assign sel_dir = |(grant & bus.req_dir);

  rot4_unit u_rot (.data(sel_data), .amt(sel_amt), .dir(sel_dir), .result(rot_data));
`else
  rot4_unit u_rot (.data(sel_data), .amt(sel_amt), .result(rot_data));
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= EMPTY;
      out_data_reg   <= '0;
      out_id_reg     <= '0;
      last_grant_reg <= IDW'(NREQ - 1);
`ifdef ROT_SHARE_DIR_EN
      out_dir_reg    <= 1'b0;
`endif
    end else begin
      case (state_reg)
        EMPTY: if (accept) state_reg <= FULL;
        FULL:  if (bus.out_ready && !accept) state_reg <= EMPTY;
        default: state_reg <= EMPTY;
      endcase
      if (accept) begin
        out_data_reg   <= rot_data;
        out_id_reg     <= sel_id;
        last_grant_reg <= sel_id;
`ifdef ROT_SHARE_DIR_EN
        out_dir_reg    <= sel_dir;
`endif
      end
    end
  end

  assign bus.out_valid = (state_reg == FULL);
  assign bus.out_data  = out_data_reg;
  assign bus.out_id    = out_id_reg;
`ifdef ROT_SHARE_DIR_EN
  assign bus.out_dir   = out_dir_reg;
`endif

endmodule

// File: tb/tb_rot_share_arb.sv
// Directed-vector bench for rot_share_arb with NREQ=2; inputs change on negedge, checks #1 later.
module tb_rot_share_arb;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  rot_share_arb_if #(.NREQ(2), .IDW(2)) bus ();

  rot_share_arb #(.NREQ(2), .IDW(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end else begin
      $display("ok   %s: got=%0h", name, got);
    end
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_data  = 8'hA5;
    bus.req_amt   = 4'b0110;
    bus.out_ready = 1'b0;
`ifdef ROT_SHARE_DIR_EN
    bus.req_dir   = 2'b00;
`endif
    @(posedge clk);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL reset_ready: got=%b want=00", bus.req_ready); end
      total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b want=0", bus.out_valid); end
      total++; if (bus.out_data !== 4'h0) begin bad++; $display("FAIL reset_data: got=%h want=0", bus.out_data); end
      total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL reset_id: got=%0d want=0", bus.out_id); end
      $display("reset cycle %0d checked", c);
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.req_valid = 2'b01;
    bus.req_data  = 8'h0B;
    bus.req_amt   = 4'b0011;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready: got=%b want=01", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 4'b0111) begin bad++; $display("FAIL single_data: got=%b want=0111", bus.out_data); end
    total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL single_id: got=%0d want=0", bus.out_id); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL single_idle_ready: got=%b want=00", bus.req_ready); end
    @(negedge clk); #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL single_drain: got=%b want=0", bus.out_valid); end
    $display("single request: data=%b id=%0d", 4'b0111, 0);
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_ready;
    logic [3:0] exp_data;
    logic [1:0] exp_id;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.req_data  = {4'b1011, 4'b1000};
    bus.req_amt   = {2'd2, 2'd1};
    bus.req_valid = 2'b11;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      exp_ready = (i % 2 == 0) ? 2'b01 : 2'b10;
      total++; if (bus.req_ready !== exp_ready) begin bad++; $display("FAIL rr_ready[%0d]: got=%b want=%b", i, bus.req_ready, exp_ready); end
      if (i > 0) begin
        exp_id   = ((i - 1) % 2 == 0) ? 2'd0 : 2'd1;
        exp_data = (exp_id == 2'd0) ? 4'b0100 : 4'b1110;
        total++; if (bus.out_id !== exp_id) begin bad++; $display("FAIL rr_id[%0d]: got=%0d want=%0d", i, bus.out_id, exp_id); end
        total++; if (bus.out_data !== exp_data) begin bad++; $display("FAIL rr_data[%0d]: got=%b want=%b", i, bus.out_data, exp_data); end
      end
      $display("round robin step %0d ready=%b", i, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rr_last_valid: got=%b want=1", bus.out_valid); end
    total++; if (bus.out_id !== 2'd1) begin bad++; $display("FAIL rr_last_id: got=%0d want=1", bus.out_id); end
    total++; if (bus.out_data !== 4'b1110) begin bad++; $display("FAIL rr_last_data: got=%b want=1110", bus.out_data); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_data  = {4'b0011, 4'b0110};
    bus.req_amt   = {2'd1, 2'd0};
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_load_ready: got=%b want=01", bus.req_ready); end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.req_valid = 2'b10;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_ready[%0d]: got=%b want=00", c, bus.req_ready); end
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d]: got=%b want=1", c, bus.out_valid); end
      total++; if (bus.out_data !== 4'b0110) begin bad++; $display("FAIL bp_data[%0d]: got=%b want=0110", c, bus.out_data); end
      total++; if (bus.out_id !== 2'd0) begin bad++; $display("FAIL bp_id[%0d]: got=%0d want=0", c, bus.out_id); end
      $display("backpressure hold cycle %0d", c);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bp_release_ready: got=%b want=10", bus.req_ready); end
    @(negedge clk);
    bus.req_valid = 2'b00;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_after_valid: got=%b want=1", bus.out_valid); end
    total++; if (bus.out_id !== 2'd1) begin bad++; $display("FAIL bp_after_id: got=%0d want=1", bus.out_id); end
    total++; if (bus.out_data !== 4'b1001) begin bad++; $display("FAIL bp_after_data: got=%b want=1001", bus.out_data); end
  endtask

  task automatic test_reset_mid_hold();
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_data  = {4'b0101, 4'b1100};
    bus.req_amt   = {2'd0, 2'd2};
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.req_valid = 2'b11;
    #1;
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL rh_valid: got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== 4'b0011) begin bad++; $display("FAIL rh_data: got=%b want=0011", bus.out_data); end
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rh_ready: got=%b want=00", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rh_rst_ready: got=%b want=00", bus.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rh_post_valid: got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 4'b0000) begin bad++; $display("FAIL rh_post_data: got=%b want=0000", bus.out_data); end
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rh_post_ready: got=%b want=01", bus.req_ready); end
    $display("reset mid-hold: pointer back to requester 0");
    @(negedge clk);
    bus.req_valid = 2'b00;
  endtask

`ifdef ROT_SHARE_DIR_EN
  task automatic test_dir();
    @(negedge clk);
    bus.req_valid = 2'b01;
    bus.req_data  = {4'b0000, 4'b1000};
    bus.req_amt   = {2'd0, 2'd1};
    bus.req_dir   = 2'b01;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 2'b00;
    bus.req_dir   = 2'b00;
    #1;
    total++; if (bus.out_data !== 4'b0001) begin bad++; $display("FAIL dir_data: got=%b want=0001", bus.out_data); end
    total++; if (bus.out_dir !== 1'b1) begin bad++; $display("FAIL dir_flag: got=%b want=1", bus.out_dir); end
    $display("direction left: data=%b", bus.out_data);
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_mid_hold();
`ifdef ROT_SHARE_DIR_EN
    test_dir();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rot_share_arb.md
Name: rot_share_arb

Overview:
- Shares a single 4-bit rotate-right unit between NREQ requesters.
- Each requester presents a data nibble and a rotate amount on a valid/ready handshake.
- A round-robin arbiter grants one request per cycle; the rotated result is registered and tagged with the requester index.
- The result register drives a downstream valid/ready consumer. The block sits between the control masters and the shared shift datapath.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- IDW, 2, width of result_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising clk.
- req_valid  input  NREQ  per-requester request valid.
- req_data  input  4*NREQ  flattened nibbles; requester i at [4*i+3:4*i].
- req_amt  input  2*NREQ  flattened rotate amounts; requester i at [2*i+1:2*i].
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- out_valid  output  1  result register holds a valid result.
- out_data  output  4  rotated nibble.
- out_id  output  IDW  index of the requester that produced out_data.
- out_ready  input  1  downstream accepts the result this cycle.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - out_valid=0, out_data=0, out_id=0.
  - Round-robin pointer last_grant=NREQ-1, so requester 0 has first priority.
  - req_ready=0 while rst_n=0.
  - Reset mid-transaction discards the held result; no handshake completes in that cycle.
- Rotate rule (amt → out_data, q = selected req_data):
  - 0 → q.
  - 1 → {q[0],q[3:1]}.
  - 2 → {q[1:0],q[3:2]}.
  - 3 → {q[2:0],q[3]}.
- load_en = !out_valid || out_ready; this is pipelined, so a new result can load in the same cycle the old one drains.
- Arbitration:
  - Search from (last_grant+1) mod NREQ upward with wrap and pick the first i with req_valid[i]=1.
  - req_ready[i] = load_en && grant[i].
  - req_ready is combinational from req_valid, out_valid and out_ready.
- Transfer:
  - A request transfers when req_valid[i] && req_ready[i].
  - On the next edge: out_data = rotate(req_data[i], req_amt[i]), out_id = i, out_valid = 1, last_grant = i.
  - Latency from accepted request to out_valid is 1 cycle.
- If load_en and no req_valid: out_valid goes to 0 when out_ready drains it; last_grant is unchanged.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_id are held stable and every req_ready=0.
- Requesters must hold req_data and req_amt stable while req_valid=1 and not yet accepted. The arbiter's decision may change between cycles if other valids rise.
- Fairness: with all requesters continuously valid and out_ready=1, the grant order is 0,1,...,NREQ-1,0,...; no requester waits more than NREQ-1 transfers.
- FSM, two states:
  - EMPTY (out_valid=0) → FULL on any accept.
  - FULL → FULL on accept with out_ready=1.
  - FULL → EMPTY on out_ready=1 with no accept.
  - FULL → FULL (hold) on out_ready=0.
- Never more than one req_ready asserted per cycle.

Optional Feature:
- Macro ROT_SHARE_DIR_EN.
- Defined:
  - Adds input req_dir [NREQ-1:0]; req_dir[i]=1 selects rotate-left by amt for requester i.
  - Left rotate is implemented as rotate-right by (4-amt) mod 4.
  - The registered result also carries out_dir (output, 1), the direction used.
- Undefined: req_dir and out_dir ports are absent; every request is rotate-right. Behaviour is otherwise identical.

Decomposition:
- Shared package rot_share_pkg holds:
  - DATA_W=4 and AMT_W=2 constants.
  - Typedef rot_amt_t (logic [1:0]).
  - Enum out_state_e {EMPTY, FULL}.
  - Function rot_right(data, amt).
- One natural sub-module: rot4_unit, a combinational 4-bit rotator taking data, amt and (with the macro) dir. The top level instantiates it once, after the grant mux.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with all req_valid=1 → req_ready=0, out_valid=0, out_data=0, out_id=0 throughout.
- Single request: req0 data=4'b1011 amt=3, out_ready=1 → req_ready[0]=1 that cycle; next cycle out_valid=1, out_data=4'b0111, out_id=0.
- Round robin: NREQ=2, both valid every cycle (data0=4'b1000 amt=1, data1=4'b1011 amt=2), out_ready=1 → ids 0,1,0,1 with data 4'b0100, 4'b1110 alternating.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles with req1 valid → out_data/out_id stable, req_ready=0; out_ready=1 → req1 accepted the same cycle and its result appears the next cycle.
- Reset mid-hold: out_valid=1 with out_ready=0, then rst_n=0 one cycle → out_valid=0 and the pointer returns to requester-0 priority.
- ROT_SHARE_DIR_EN: data=4'b1000 amt=1 dir=1 → out_data=4'b0001, out_dir=1.
